// File: rtl/drive_arbiter.sv
// drive_arbiter: turns target direction/distance, audio events and IR remote
// codes into a debounced 3-bit drive command. The command is offered to the
// motor controller over a valid/ready handshake.
module drive_arbiter #(
    parameter int          FOV                 = 25,
    parameter int          FAST_LEFT_MAX       = 6,
    parameter int          LEFT_MAX            = 8,
    parameter int          STRAIGHT_MAX        = 16,
    parameter int          RIGHT_MAX           = 19,
    parameter int          STOP_DISTANCE       = 20,
    parameter int          AMPLITUDE_THRESHOLD = 4,
    parameter int          MAX_CLAP_PITCH      = 4,
    parameter int          MIN_WHISTLE_PITCH   = 12,
    parameter logic [31:0] IR_GO_CODE          = 32'h00FF_629D,
    parameter logic [31:0] IR_STOP_CODE        = 32'h00FF_A857,
    parameter int          HOLD_CYCLES         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 no_red,
    input  logic [$clog2(FOV):0] detected_direction,
    input  logic [7:0]           average_distance,
    input  logic [3:0]           pitch,
    input  logic [3:0]           amplitude,
    input  logic                 ir_valid,
    input  logic [31:0]          ir_command,
    input  logic                 ready,
    output logic [2:0]           drive_command,
    output logic                 valid,
    output logic                 armed
);

    localparam int DIR_W = $clog2(FOV) + 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        CMD_STOP       = 3'd0,
        CMD_FAST_LEFT  = 3'd1,
        CMD_LEFT       = 3'd2,
        CMD_STRAIGHT   = 3'd3,
        CMD_RIGHT      = 3'd4,
        CMD_FAST_RIGHT = 3'd5
    } cmd_t;

    // Thresholds resized once so every comparison below is width-matched and unsigned.
    localparam logic [DIR_W-1:0] FL_LIM      = DIR_W'(FAST_LEFT_MAX);
    localparam logic [DIR_W-1:0] L_LIM       = DIR_W'(LEFT_MAX);
    localparam logic [DIR_W-1:0] S_LIM       = DIR_W'(STRAIGHT_MAX);
    localparam logic [DIR_W-1:0] R_LIM       = DIR_W'(RIGHT_MAX);
    localparam logic [7:0]       STOP_LIM    = 8'(STOP_DISTANCE);
    localparam logic [3:0]       AMP_LIM     = 4'(AMPLITUDE_THRESHOLD);
    localparam logic [3:0]       CLAP_LIM    = 4'(MAX_CLAP_PITCH);
    localparam logic [3:0]       WHISTLE_LIM = 4'(MIN_WHISTLE_PITCH);
    localparam logic [CNT_W-1:0] HOLD        = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             r_armed;
    cmd_t             r_pending;
    logic [CNT_W-1:0] r_count;
    cmd_t             r_committed;
    cmd_t             r_accepted;
    cmd_t             r_drive_command;
    logic             r_valid;

    logic             w_loud;
    logic             w_disarm;
    logic             w_arm;
    cmd_t             w_candidate;
    logic [CNT_W-1:0] w_count_next;
    logic             w_commit;

    // Audio and IR event decode; a disarm request always outranks an arm request.
    assign w_loud   = amplitude > AMP_LIM;
    assign w_disarm = (w_loud && (pitch < CLAP_LIM)) ||
                      (ir_valid && (ir_command == IR_STOP_CODE));
    assign w_arm    = (w_loud && (pitch > WHISTLE_LIM)) ||
                      (ir_valid && (ir_command == IR_GO_CODE));

    // Arm state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (w_disarm) begin
            r_armed <= 1'b0;
        end else if (w_arm) begin
            r_armed <= 1'b1;
        end
    end

    // Candidate command from the registered arm state, distance and direction zone.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_candidate = CMD_STOP;
        if (!r_armed || no_red || (average_distance < STOP_LIM)) begin
            w_candidate = CMD_STOP;
        end else if (detected_direction < FL_LIM) begin
            w_candidate = CMD_FAST_LEFT;
        end else if (detected_direction < L_LIM) begin
            w_candidate = CMD_LEFT;
        end else if (detected_direction < S_LIM) begin
            w_candidate = CMD_STRAIGHT;
        end else if (detected_direction < R_LIM) begin
            w_candidate = CMD_RIGHT;
        end else begin
            w_candidate = CMD_FAST_RIGHT;
        end
    end

    // Run-length of the current candidate; a change restarts the run at one sample.
    always_comb begin
        w_count_next = CNT_ONE;
        if (w_candidate == r_pending) begin
            w_count_next = (r_count == HOLD) ? HOLD : (r_count + CNT_ONE);
        end
    end

    // Stop bypasses the debounce for safety; other commands need a full run.
    // Re-committing the same value once saturated is harmless.
    assign w_commit = (w_candidate == CMD_STOP) || (w_count_next == HOLD);

    // Debounce registers: pending candidate, its run length and the committed command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= CMD_STOP;
            r_count     <= '0;
            r_committed <= CMD_STOP;
        end else begin
            r_pending <= w_candidate;
            r_count   <= w_count_next;
            if (w_commit) begin
                r_committed <= w_candidate;
            end
        end
    end

    // Handshake: offer the committed command when it differs from the last
    // accepted one, and hold the offer stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drive_command <= CMD_STOP;
            r_valid         <= 1'b0;
            r_accepted      <= CMD_STOP;
        end else if (r_valid) begin
            if (ready) begin
                r_accepted <= r_drive_command;
                r_valid    <= 1'b0;
            end
        end else if (r_committed != r_accepted) begin
            r_drive_command <= r_committed;
            r_valid         <= 1'b1;
        end
    end

    assign drive_command = r_drive_command;
    assign valid         = r_valid;
    assign armed         = r_armed;

endmodule

// File: tb/tb_drive_arbiter.sv
// Self-checking bench for drive_arbiter: directed steps drive the inputs,
// expected commands are queued when stimulus is applied and popped when the
// DUT completes a transfer.
module tb_drive_arbiter;

    localparam logic [31:0] GO_CODE   = 32'h00FF_629D;
    localparam logic [31:0] STOP_CODE = 32'h00FF_A857;
    localparam int          HOLD      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        no_red;
    logic [5:0]  detected_direction;
    logic [7:0]  average_distance;
    logic [3:0]  pitch;
    logic [3:0]  amplitude;
    logic        ir_valid;
    logic [31:0] ir_command;
    logic        ready;
    logic [2:0]  drive_command;
    logic        valid;
    logic        armed;

    int n_pass      = 0;
    int n_total     = 0;
    int n_valid_cyc = 0;
    int mark;

    logic [2:0] q_exp[$];

    drive_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .no_red             (no_red),
        .detected_direction (detected_direction),
        .average_distance   (average_distance),
        .pitch              (pitch),
        .amplitude          (amplitude),
        .ir_valid           (ir_valid),
        .ir_command         (ir_command),
        .ready              (ready),
        .drive_command      (drive_command),
        .valid              (valid),
        .armed              (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            $error("check %s did not hold", tag);
        end
    endtask

    // Advance n clock edges; inputs change 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transfer monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_cmd;
        if (rst_n && valid) n_valid_cyc++;
        if (rst_n && valid && ready) begin
            if (q_exp.size() > 0) exp_cmd = {29'b0, q_exp.pop_front()};
            else                  exp_cmd = 32'hFFFF_FFFF;
            check("sb_transfer", {29'b0, drive_command}, exp_cmd);
        end
    end

    // Direction table: plan sweep then zone boundaries, with expected zones.
    logic [5:0] sweep_dir [11] = '{6'd2, 6'd7, 6'd17, 6'd22, 6'd5, 6'd6, 6'd8, 6'd16, 6'd19, 6'd18, 6'd15};
    logic [2:0] sweep_cmd [11] = '{3'd1, 3'd2, 3'd4,  3'd5,  3'd1, 3'd2, 3'd3, 3'd4,  3'd5,  3'd4,  3'd3};

    initial begin
        rst_n              = 1'b0;
        no_red             = 1'b0;
        detected_direction = 6'd10;
        average_distance   = 8'd50;
        pitch              = 4'd0;
        amplitude          = 4'd0;
        ir_valid           = 1'b0;
        ir_command         = 32'h0;
        ready              = 1'b1;

        // Reset state.
        step(2);
        check("rst_armed", {31'b0, armed}, 0);
        check("rst_valid", {31'b0, valid}, 0);
        check("rst_cmd",   {29'b0, drive_command}, 0);
        rst_n = 1'b1;

        // Disarmed: nothing is ever offered.
        mark = n_valid_cyc;
        step(20);
        check("disarmed_no_offer", n_valid_cyc - mark, 0);
        check("disarmed_cmd", {29'b0, drive_command}, 0);

        // IR GO arms; Straight offered HOLD+1 edges after arming.
        ir_valid   = 1'b1;
        ir_command = GO_CODE;
        q_exp.push_back(3'd3);
        step(1);
        check("ir_go_armed", {31'b0, armed}, 1);
        ir_valid = 1'b0;
        step(HOLD);
        check("latency_not_early", {31'b0, valid}, 0);
        step(1);
        check("latency_valid", {31'b0, valid}, 1);
        check("latency_cmd", {29'b0, drive_command}, 3);
        step(4);
        check("single_transfer_idle", {31'b0, valid}, 0);

        // Direction sweep and zone boundaries, one transfer each.
        for (int i = 0; i < 11; i++) begin
            detected_direction = sweep_dir[i];
            q_exp.push_back(sweep_cmd[i]);
            step(10);
        end
        check("sweep_drained", q_exp.size(), 0);

        // Glitch shorter than HOLD never commits.
        detected_direction = 6'd10;
        step(5);
        mark = n_valid_cyc;
        detected_direction = 6'd5;
        step(HOLD - 1);
        detected_direction = 6'd10;
        step(12);
        check("glitch_no_offer", n_valid_cyc - mark, 0);

        // Back-pressure: Straight held while ready=0, Stop offered after transfer.
        detected_direction = 6'd22;
        q_exp.push_back(3'd5);
        step(10);
        ready = 1'b0;
        detected_direction = 6'd10;
        q_exp.push_back(3'd3);
        step(HOLD + 2);
        check("bp_valid", {31'b0, valid}, 1);
        check("bp_cmd", {29'b0, drive_command}, 3);
        average_distance = 8'd10;
        q_exp.push_back(3'd0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_hold_cmd", {29'b0, drive_command}, 3);
            check("bp_hold_valid", {31'b0, valid}, 1);
        end
        ready = 1'b1;
        step(1);
        check("bp_gap", {31'b0, valid}, 0);
        step(1);
        check("bp_reoffer_valid", {31'b0, valid}, 1);
        check("bp_reoffer_cmd", {29'b0, drive_command}, 0);
        step(3);

        // Clap and IR GO in the same cycle: disarm wins, Stop offered 2 edges later.
        average_distance = 8'd50;
        q_exp.push_back(3'd3);
        step(10);
        amplitude  = 4'd9;
        pitch      = 4'd2;
        ir_valid   = 1'b1;
        ir_command = GO_CODE;
        q_exp.push_back(3'd0);
        step(1);
        check("clap_wins", {31'b0, armed}, 0);
        amplitude = 4'd0;
        pitch     = 4'd0;
        ir_valid  = 1'b0;
        step(1);
        check("clap_stop_gap", {31'b0, valid}, 0);
        step(1);
        check("clap_stop_valid", {31'b0, valid}, 1);
        check("clap_stop_cmd", {29'b0, drive_command}, 0);
        step(3);

        // Arm decode corner cases with no target, so no commands change.
        no_red     = 1'b1;
        ir_command = GO_CODE;
        step(1);
        check("ir_ignored_no_strobe", {31'b0, armed}, 0);
        ir_valid   = 1'b1;
        ir_command = 32'h1234_5678;
        step(1);
        check("ir_unknown_code", {31'b0, armed}, 0);
        ir_valid  = 1'b0;
        amplitude = 4'd9;
        pitch     = 4'd12;
        step(1);
        check("whistle_pitch_edge", {31'b0, armed}, 0);
        pitch = 4'd13;
        step(1);
        check("whistle_arms", {31'b0, armed}, 1);
        amplitude = 4'd4;
        pitch     = 4'd2;
        step(1);
        check("quiet_clap_ignored", {31'b0, armed}, 1);
        amplitude = 4'd9;
        pitch     = 4'd4;
        step(1);
        check("clap_pitch_edge", {31'b0, armed}, 1);
        amplitude  = 4'd0;
        pitch      = 4'd0;
        ir_valid   = 1'b1;
        ir_command = STOP_CODE;
        step(1);
        check("ir_stop_disarms", {31'b0, armed}, 0);
        ir_valid = 1'b0;
        step(2);

        // Reset mid-handshake drops valid at once; nothing re-offered afterwards.
        no_red     = 1'b0;
        ready      = 1'b0;
        ir_valid   = 1'b1;
        ir_command = GO_CODE;
        step(1);
        ir_valid = 1'b0;
        step(HOLD + 2);
        check("pre_reset_offer", {31'b0, valid}, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, valid}, 0);
        check("async_rst_armed", {31'b0, armed}, 0);
        check("async_rst_cmd", {29'b0, drive_command}, 0);
        step(2);
        ready = 1'b1;
        rst_n = 1'b1;
        mark  = n_valid_cyc;
        step(12);
        check("post_reset_no_offer", n_valid_cyc - mark, 0);

        check("scoreboard_empty", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
Successor to the single-mode drive decision block. Converts red-target direction, distance, sound (clap/whistle) and IR remote inputs into a debounced 3-bit drive command. Direction zone boundaries are parametrised and all six zones are used. Output goes to the motor controller over a valid/ready handshake.

Parameters:
FOV, 25, camera field-of-view bins; direction width is $clog2(FOV)+1
FAST_LEFT_MAX, 6, direction < this -> Fast_left
LEFT_MAX, 8, direction < this -> Left
STRAIGHT_MAX, 16, direction < this -> Straight
RIGHT_MAX, 19, direction < this -> Right; otherwise Fast_right
STOP_DISTANCE, 20, average_distance < this forces Stop (target too close)
AMPLITUDE_THRESHOLD, 4, sound event needs amplitude > this
MAX_CLAP_PITCH, 4, pitch < this with loud amplitude = clap (disarm)
MIN_WHISTLE_PITCH, 12, pitch > this with loud amplitude = whistle (arm)
IR_GO_CODE, 32'h00FF_629D, IR code that arms
IR_STOP_CODE, 32'h00FF_A857, IR code that disarms
HOLD_CYCLES, 4, consecutive samples needed to commit a non-Stop command (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
no_red  in  1  no target in frame
detected_direction  in  $clog2(FOV)+1  target bin, 0 = leftmost
average_distance  in  8  target distance estimate
pitch  in  4  audio pitch bin
amplitude  in  4  audio amplitude bin
ir_valid  in  1  one-cycle strobe, ir_command valid
ir_command  in  32  decoded IR code
ready  in  1  motor controller accepts command
drive_command  out  3  0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right
valid  out  1  drive_command is offered
armed  out  1  drive enable state

Behaviour:
- Reset (async assert, sync release): armed=0, valid=0, drive_command=0. Internal pending=Stop, committed=Stop, accepted=Stop, hold count=0.
- Arm logic, per edge:
  - disarm on clap (amplitude>AMPLITUDE_THRESHOLD && pitch<MAX_CLAP_PITCH) or on ir_valid && ir_command==IR_STOP_CODE;
  - else arm on whistle (amplitude>AMPLITUDE_THRESHOLD && pitch>MIN_WHISTLE_PITCH) or on ir_valid && ir_command==IR_GO_CODE;
  - disarm wins when both occur in the same cycle; ir_command is ignored when ir_valid=0; unknown IR codes are ignored.
- Candidate (combinational, uses registered armed):
  - Stop if !armed, no_red, or average_distance<STOP_DISTANCE;
  - otherwise the first matching zone in FAST_LEFT_MAX, LEFT_MAX, STRAIGHT_MAX, RIGHT_MAX order, else Fast_right;
  - all comparisons unsigned, strict less-than.
- Debounce:
  - if candidate!=pending: pending<=candidate, count<=1;
  - else count increments, saturating at HOLD_CYCLES.
  - Stop candidate commits on the same edge it is first sampled (safety bypass).
  - Non-Stop commits on the edge where count reaches HOLD_CYCLES, i.e. after HOLD_CYCLES consecutive equal samples. HOLD_CYCLES=1 commits immediately.
  - A glitch of any length <HOLD_CYCLES never changes committed.
- Handshake:
  - when valid=0 and committed!=accepted: on the next edge load drive_command<=committed, valid<=1.
  - transfer occurs on an edge with valid && ready; then accepted<=drive_command and valid<=0 on that edge.
  - while valid && !ready, drive_command and valid hold stable; newer commits wait.
  - after a transfer, if committed!=accepted, re-offer starting on the following edge (one idle cycle between offers).
- Latency: Stop input to valid=1 is 2 edges; non-Stop input to valid=1 is HOLD_CYCLES+1 edges.
- Reset mid-handshake drops valid immediately; no command is re-offered unless committed later differs from Stop.
- No duplicate offers: a command equal to accepted is never re-offered.

Test Plan:
- Reset, armed=0, direction=10 held 20 cycles, ready=1 -> valid never asserts, drive_command=0.
- IR ir_valid pulse with 32'h00FF_629D, no_red=0, distance=50, direction=10 -> armed=1 next edge; valid=1 with drive_command=3 exactly HOLD_CYCLES+1 edges after arming; single transfer.
- Armed, direction sweep 2, 7, 17, 22, each held 10 cycles, ready=1 -> offers 1, 2, 4, 5 in order, one transfer each.
- Armed, Straight accepted; direction=5 for 3 cycles then back to 10 -> no offer (glitch < HOLD_CYCLES).
- Armed, ready=0, Straight offered; distance drops to 10 -> drive_command stays 3 until ready=1; next offer is 0 one cycle after the transfer.
- Same-cycle clap (amplitude=9, pitch=2) and IR GO -> armed=0; Stop offered 2 edges later if last accepted was non-Stop.
